id_ex_pipe: RTL and testbench

Decode-to-execute pipeline register for the MIPS pipeline. It sits directly downstream of the register file: it captures the A/B operands, the decoded instruction fields and the control-unit bits each cycle, and presents them registered to the EX stage. It also contains load-use hazard detection: it drives stall_out to hold PC and IF/ID, and it inserts bubbles on hazard or on a branch flush.

---
 rtl/id_ex_pipe.sv | 89 ++++++++
 tb/tb_id_ex_pipe.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use hazard detection and bubble insertion.
module id_ex_pipe #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   instr_in,
   input  logic [31:0]   npc_in,
   input  logic          valid_in,
   input  logic [DW-1:0] A_in,
   input  logic [DW-1:0] B_in,
   input  logic [1:0]    ctl_wb_in,
   input  logic [2:0]    ctl_m_in,
   input  logic [3:0]    ctl_ex_in,
   input  logic          flush,
   output logic          stall_out,
   output logic [DW-1:0] ex_A,
   output logic [DW-1:0] ex_B,
   output logic [DW-1:0] ex_imm,
   output logic [4:0]    ex_rt,
   output logic [4:0]    ex_rd,
   output logic [31:0]   ex_npc,
   output logic [1:0]    ex_ctl_wb,
   output logic [2:0]    ex_ctl_m,
   output logic [3:0]    ex_ctl_ex,
   output logic          ex_valid,
   output logic [CW-1:0] bubble_cnt
);
   typedef struct packed {
      logic          valid;
      logic [1:0]    wb;
      logic [2:0]    m;
      logic [3:0]    ex;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] imm;
      logic [4:0]    rt;
      logic [4:0]    rd;
      logic [31:0]   npc;
   } stage_t;
   stage_t        st_d, st_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic [4:0]    rs, rt;
   logic          hazard, bubble;
   assign rs = instr_in[25:21];
   assign rt = instr_in[20:16];
   // Conservative: both source fields are compared regardless of opcode.
   assign hazard = valid_in & st_q.valid & st_q.m[1] & (st_q.rt != 5'd0) &
                   ((st_q.rt == rs) | (st_q.rt == rt));
   assign bubble = flush | hazard;
   assign stall_out = hazard & ~flush;
   always_comb begin
      st_d = '0;
      if (!bubble) begin
         st_d.valid = valid_in;
         st_d.wb    = valid_in ? ctl_wb_in : 2'b0;
         st_d.m     = valid_in ? ctl_m_in : 3'b0;
         st_d.ex    = valid_in ? ctl_ex_in : 4'b0;
         st_d.a     = A_in;
         st_d.b     = B_in;
         st_d.imm   = {{(DW-16){instr_in[15]}}, instr_in[15:0]};
         st_d.rt    = rt;
         st_d.rd    = instr_in[15:11];
         st_d.npc   = npc_in;
      end
      cnt_d = (bubble && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= '0;
         cnt_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end
   assign ex_valid   = st_q.valid;
   assign ex_ctl_wb  = st_q.wb;
   assign ex_ctl_m   = st_q.m;
   assign ex_ctl_ex  = st_q.ex;
   assign ex_A       = st_q.a;
   assign ex_B       = st_q.b;
   assign ex_imm     = st_q.imm;
   assign ex_rt      = st_q.rt;
   assign ex_rd      = st_q.rd;
   assign ex_npc     = st_q.npc;
   assign bubble_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed-vector bench for id_ex_pipe, plus a CW=2 instance for saturation.
module tb_id_ex_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr_in, npc_in, A_in, B_in;
   logic        valid_in, flush;
   logic [1:0]  ctl_wb_in;
   logic [2:0]  ctl_m_in;
   logic [3:0]  ctl_ex_in;
   logic        stall_out, ex_valid, stall2, valid2;
   logic [31:0] ex_A, ex_B, ex_imm, ex_npc, a2, b2, imm2, npc2;
   logic [4:0]  ex_rt, ex_rd, rt2, rd2;
   logic [1:0]  ex_ctl_wb, wb2;
   logic [2:0]  ex_ctl_m, m2;
   logic [3:0]  ex_ctl_ex, ex2;
   logic [15:0] bubble_cnt;
   logic [1:0]  cnt2;
   int          n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   id_ex_pipe dut (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .npc_in(npc_in), .valid_in(valid_in),
      .A_in(A_in), .B_in(B_in), .ctl_wb_in(ctl_wb_in), .ctl_m_in(ctl_m_in), .ctl_ex_in(ctl_ex_in),
      .flush(flush), .stall_out(stall_out), .ex_A(ex_A), .ex_B(ex_B), .ex_imm(ex_imm),
      .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_npc(ex_npc), .ex_ctl_wb(ex_ctl_wb), .ex_ctl_m(ex_ctl_m),
      .ex_ctl_ex(ex_ctl_ex), .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
   );

   id_ex_pipe #(.DW(32), .CW(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .npc_in(npc_in), .valid_in(valid_in),
      .A_in(A_in), .B_in(B_in), .ctl_wb_in(ctl_wb_in), .ctl_m_in(ctl_m_in), .ctl_ex_in(ctl_ex_in),
      .flush(flush), .stall_out(stall2), .ex_A(a2), .ex_B(b2), .ex_imm(imm2),
      .ex_rt(rt2), .ex_rd(rd2), .ex_npc(npc2), .ex_ctl_wb(wb2), .ex_ctl_m(m2),
      .ex_ctl_ex(ex2), .ex_valid(valid2), .bubble_cnt(cnt2)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [1:0] wb,
                        input logic [2:0] m, input logic [3:0] ex, input logic v, input logic f);
      instr_in = ins; A_in = a; B_in = a + 32'h100; npc_in = 32'h400 + a;
      ctl_wb_in = wb; ctl_m_in = m; ctl_ex_in = ex; valid_in = v; flush = f;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(32'h0, 32'h0, 2'b0, 3'b0, 4'b0, 1'b0, 1'b0);
      #2;
      chk("rst_valid", ex_valid, 0);
      chk("rst_cnt", bubble_cnt, 0);
      chk("rst_stall", stall_out, 0);
      tick();
      rst_n = 1'b1;
      // five flushes: CW=16 counts to 5, CW=2 saturates at 3
      drive(32'h8C220004, 32'h10, 2'b11, 3'b010, 4'b0011, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) tick();
      chk("flush5_cnt", bubble_cnt, 5);
      chk("sat_cnt2", cnt2, 3);
      chk("flush_valid", ex_valid, 0);
      flush = 1'b0;
      tick();
      chk("pre_rst_valid", ex_valid, 1);
      chk("pre_rst_cnt", bubble_cnt, 5);
      drive(32'h00441820, 32'h33, 2'b10, 3'b000, 4'b1100, 1'b1, 1'b0);
      #1;
      chk("pre_rst_stall", stall_out, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_valid", ex_valid, 0);
      chk("async_cnt", bubble_cnt, 0);
      chk("async_A", ex_A, 0);
      chk("async_ctl_m", ex_ctl_m, 0);
      chk("async_stall", stall_out, 0);
      #1 rst_n = 1'b1;
      // normal capture of lw $2,4($1)
      drive(32'h8C220004, 32'h10, 2'b11, 3'b010, 4'b0011, 1'b1, 1'b0);
      tick();
      chk("cap_rt", ex_rt, 2);
      chk("cap_imm", ex_imm, 32'h4);
      chk("cap_A", ex_A, 32'h10);
      chk("cap_B", ex_B, 32'h110);
      chk("cap_npc", ex_npc, 32'h410);
      chk("cap_ctl_m", ex_ctl_m, 3'b010);
      chk("cap_ctl_wb", ex_ctl_wb, 2'b11);
      chk("cap_valid", ex_valid, 1);
      chk("cap_cnt", bubble_cnt, 0);
      // load-use: add $3,$2,$4
      drive(32'h00441820, 32'h20, 2'b10, 3'b000, 4'b1100, 1'b1, 1'b0);
      #1;
      chk("lu_stall", stall_out, 1);
      tick();
      chk("lu_valid", ex_valid, 0);
      chk("lu_ctl_wb", ex_ctl_wb, 0);
      chk("lu_ctl_m", ex_ctl_m, 0);
      chk("lu_ctl_ex", ex_ctl_ex, 0);
      chk("lu_A", ex_A, 0);
      chk("lu_cnt", bubble_cnt, 1);
      chk("lu_stall2", stall_out, 0);
      tick();
      chk("lu_rd", ex_rd, 3);
      chk("lu_cap_valid", ex_valid, 1);
      chk("lu_cap_wb", ex_ctl_wb, 2'b10);
      chk("lu_cap_cnt", bubble_cnt, 1);
      // sign extension
      drive(32'h2022FFFC, 32'h1, 2'b10, 3'b000, 4'b0001, 1'b1, 1'b0);
      tick();
      chk("sext_neg", ex_imm, 32'hFFFFFFFC);
      drive(32'h20227FFF, 32'h1, 2'b10, 3'b000, 4'b0001, 1'b1, 1'b0);
      tick();
      chk("sext_pos", ex_imm, 32'h00007FFF);
      // flush overrides a pending hazard
      drive(32'h8C220004, 32'h10, 2'b11, 3'b010, 4'b0011, 1'b1, 1'b0);
      tick();
      drive(32'h00441820, 32'h20, 2'b10, 3'b000, 4'b1100, 1'b1, 1'b1);
      #1;
      chk("fh_stall", stall_out, 0);
      tick();
      chk("fh_valid", ex_valid, 0);
      chk("fh_cnt", bubble_cnt, 2);
      flush = 1'b0;
      #1;
      chk("fh_stall2", stall_out, 0);
      tick();
      chk("fh_cap_valid", ex_valid, 1);
      chk("fh_cap_rd", ex_rd, 3);
      chk("fh_cap_cnt", bubble_cnt, 2);
      // lw $0 then add using $0: no stall
      drive(32'h8C000004, 32'h10, 2'b11, 3'b010, 4'b0011, 1'b1, 1'b0);
      tick();
      drive(32'h00001820, 32'h20, 2'b10, 3'b000, 4'b1100, 1'b1, 1'b0);
      #1;
      chk("r0_stall", stall_out, 0);
      tick();
      chk("r0_valid", ex_valid, 1);
      chk("r0_cnt", bubble_cnt, 2);
      // invalid slot: data captured, controls forced off
      drive(32'h8C650008, 32'h55, 2'b11, 3'b010, 4'b0011, 1'b0, 1'b0);
      tick();
      chk("inv_valid", ex_valid, 0);
      chk("inv_ctl_m", ex_ctl_m, 0);
      chk("inv_ctl_wb", ex_ctl_wb, 0);
      chk("inv_A", ex_A, 32'h55);
      chk("inv_rt", ex_rt, 5);
      chk("inv_cnt", bubble_cnt, 2);
      chk("cnt2_end", cnt2, 2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
